// File: rtl/ar_channel_decoder_n.sv
// ar_channel_decoder_n: registered AXI4 read-address decoder routing one held AR beat
// to a slave port or a DECERR responder, with single-path outstanding tracking.
module ar_channel_decoder_n #(
  parameter int NUM_SLAVES = 4,
  parameter int MASTER_ID_W = 1,
  parameter int ADDR_W = 32,
  parameter int LEN_W = 8,
  parameter int SEL_W = $clog2(NUM_SLAVES),
  parameter logic [NUM_SLAVES-1:0] SLAVE_EN = '1,
  parameter int MAX_OUT = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [MASTER_ID_W-1:0] m_arid,
  input  logic [ADDR_W-1:0]      m_araddr,
  input  logic [LEN_W-1:0]       m_arlen,
  input  logic [2:0]             m_arsize,
  input  logic [1:0]             m_arburst,
  input  logic [1:0]             m_arlock,
  input  logic [3:0]             m_arcache,
  input  logic [2:0]             m_arprot,
  input  logic [3:0]             m_arqos,
  input  logic [3:0]             m_arregion,
  input  logic                   m_arvalid,
  output logic                   m_arready,
  output logic [MASTER_ID_W-1:0] ar_id,
  output logic [ADDR_W-1:0]      ar_addr,
  output logic [LEN_W-1:0]       ar_len,
  output logic [2:0]             ar_size,
  output logic [1:0]             ar_burst,
  output logic [1:0]             ar_lock,
  output logic [3:0]             ar_cache,
  output logic [2:0]             ar_prot,
  output logic [3:0]             ar_qos,
  output logic [3:0]             ar_region,
  output logic [NUM_SLAVES-1:0]  s_arvalid,
  input  logic [NUM_SLAVES-1:0]  s_arready,
  output logic                   decerr_valid,
  input  logic                   decerr_ready,
  output logic                   sel_push,
  output logic [NUM_SLAVES:0]    sel_onehot,
  input  logic                   r_done,
  output logic [3:0]             out_cnt
);
  localparam int PW = $clog2(NUM_SLAVES + 1);
  localparam logic [PW-1:0] ERR = PW'(NUM_SLAVES);
  localparam int PL_W = MASTER_ID_W + ADDR_W + LEN_W + 22;
  logic [SEL_W-1:0] idx;
  logic [2**SEL_W-1:0] en_ext;
  logic [PW-1:0] dec_path, cur_path_q;
  logic [NUM_SLAVES:0] rdy_ext, vld_ext;
  logic [PL_W-1:0] pl_q;
  logic hold_valid_q, hold_valid_d, blocked, issue, accept, rd;
  logic [3:0] out_cnt_q, out_cnt_d;
  assign idx = m_araddr[ADDR_W-1 -: SEL_W];
  always_comb begin
    en_ext = '0;
    en_ext[NUM_SLAVES-1:0] = SLAVE_EN;
  end
  // Unmapped or out-of-range regions go to DECERR; never fall back to slave 0.
  assign dec_path = (int'(idx) < NUM_SLAVES && en_ext[idx]) ? PW'(idx) : ERR;
  assign rdy_ext = {decerr_ready, s_arready};
  assign vld_ext = hold_valid_q ? (NUM_SLAVES+1)'(1) << cur_path_q : '0;
  assign issue = hold_valid_q & rdy_ext[cur_path_q];
  // Switching paths only after a full drain keeps R responses in order.
  assign blocked = (out_cnt_q == 4'(MAX_OUT)) | ((out_cnt_q != 4'd0) & (dec_path != cur_path_q));
  assign m_arready = ~ARESET & ~blocked & (~hold_valid_q | issue);
  assign accept = m_arvalid & m_arready;
  assign rd = r_done & (out_cnt_q != 4'd0);
  assign hold_valid_d = accept | (hold_valid_q & ~issue);
  assign out_cnt_d = out_cnt_q + 4'(accept & ~rd) - 4'(rd & ~accept);
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      hold_valid_q <= 1'b0;
      cur_path_q <= '0;
      out_cnt_q <= '0;
      pl_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      out_cnt_q <= out_cnt_d;
      if (accept) begin
        cur_path_q <= dec_path;
        pl_q <= {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos, m_arregion};
      end
    end
  end
  assign {ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region} = pl_q;
  assign s_arvalid = vld_ext[NUM_SLAVES-1:0];
  assign decerr_valid = vld_ext[NUM_SLAVES];
  assign sel_push = issue;
  assign sel_onehot = issue ? (NUM_SLAVES+1)'(1) << cur_path_q : '0;
  assign out_cnt = out_cnt_q;
endmodule

// File: tb/tb_ar_channel_decoder_n.sv
// tb_ar_channel_decoder_n: directed checks of routing, DECERR, backpressure, path blocking and counting.
module tb_ar_channel_decoder_n;
  logic clk = 1'b0, rst;
  logic [0:0] m_arid, ar_id;
  logic [31:0] m_araddr, ar_addr;
  logic [7:0] m_arlen, ar_len;
  logic [2:0] ar_size, ar_prot;
  logic [1:0] ar_burst, ar_lock;
  logic [3:0] ar_cache, ar_qos, ar_region;
  logic m_arvalid, m_arready, decerr_valid, decerr_ready, sel_push, r_done;
  logic [3:0] s_arvalid, s_arready, out_cnt;
  logic [4:0] sel_onehot;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ar_channel_decoder_n #(.NUM_SLAVES(4), .SLAVE_EN(4'b1011), .MAX_OUT(2)) dut (
    .ACLK(clk), .ARESET(rst), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(3'd2), .m_arburst(2'd1), .m_arlock(2'd0), .m_arcache(4'd3), .m_arprot(3'd0),
    .m_arqos(4'd0), .m_arregion(4'd0), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_qos(ar_qos), .ar_region(ar_region),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .decerr_valid(decerr_valid), .decerr_ready(decerr_ready),
    .sel_push(sel_push), .sel_onehot(sel_onehot), .r_done(r_done), .out_cnt(out_cnt));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain_one();
    r_done = 1'b1;
    step();
    r_done = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; m_arvalid = 1'b1; m_araddr = 32'h0; m_arid = 1'b0; m_arlen = 8'd0;
    s_arready = 4'b0; decerr_ready = 1'b0; r_done = 1'b0;
    step(); step();
    n_chk++; if (m_arready !== 1'b0) begin n_fail++; $display("FAIL reset_arready got %b want 0", m_arready); end
    n_chk++; if (s_arvalid !== 4'b0) begin n_fail++; $display("FAIL reset_svalid got %b want 0000", s_arvalid); end
    n_chk++; if (out_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", out_cnt); end
    n_chk++; if (ar_addr !== 32'h0 || decerr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_payload got %h/%b want 0/0", ar_addr, decerr_valid); end
    rst = 1'b0; m_arvalid = 1'b0;
    #1;
    n_chk++; if (m_arready !== 1'b1) begin n_fail++; $display("FAIL release_arready got %b want 1", m_arready); end
    step();
  endtask
  task automatic test_routing();
    m_araddr = 32'h4000_0010; m_arid = 1'b1; m_arlen = 8'd3; m_arvalid = 1'b1; s_arready = 4'b0010;
    #1;
    n_chk++; if (m_arready !== 1'b1) begin n_fail++; $display("FAIL route_arready got %b want 1", m_arready); end
    step();
    m_arvalid = 1'b0; m_araddr = 32'h0; m_arid = 1'b0; m_arlen = 8'd0;
    n_chk++; if (s_arvalid !== 4'b0010) begin n_fail++; $display("FAIL route_svalid got %b want 0010", s_arvalid); end
    n_chk++; if (ar_addr !== 32'h4000_0010 || ar_len !== 8'd3 || ar_id !== 1'b1) begin n_fail++; $display("FAIL route_payload got %h/%0d/%b want 40000010/3/1", ar_addr, ar_len, ar_id); end
    n_chk++; if (sel_push !== 1'b1 || sel_onehot !== 5'b00010) begin n_fail++; $display("FAIL route_sel got %b/%b want 1/00010", sel_push, sel_onehot); end
    n_chk++; if (out_cnt !== 4'd1 || ar_size !== 3'd2 || ar_cache !== 4'd3) begin n_fail++; $display("FAIL route_cnt got %0d/%0d/%0d want 1/2/3", out_cnt, ar_size, ar_cache); end
    step();
    s_arready = 4'b0;
    n_chk++; if (s_arvalid !== 4'b0 || sel_push !== 1'b0 || sel_onehot !== 5'b0) begin n_fail++; $display("FAIL route_clear got %b/%b/%b want 0", s_arvalid, sel_push, sel_onehot); end
    drain_one();
    n_chk++; if (out_cnt !== 4'd0) begin n_fail++; $display("FAIL route_drain got %0d want 0", out_cnt); end
  endtask
  task automatic test_decerr();
    m_araddr = 32'h8000_0000; m_arvalid = 1'b1;
    step();
    m_arvalid = 1'b0;
    n_chk++; if (decerr_valid !== 1'b1 || s_arvalid !== 4'b0) begin n_fail++; $display("FAIL decerr_valid got %b/%b want 1/0000", decerr_valid, s_arvalid); end
    n_chk++; if (sel_push !== 1'b0) begin n_fail++; $display("FAIL decerr_nopush got %b want 0", sel_push); end
    decerr_ready = 1'b1;
    #1;
    n_chk++; if (sel_push !== 1'b1 || sel_onehot !== 5'b10000) begin n_fail++; $display("FAIL decerr_sel got %b/%b want 1/10000", sel_push, sel_onehot); end
    step();
    decerr_ready = 1'b0;
    n_chk++; if (decerr_valid !== 1'b0 || out_cnt !== 4'd1) begin n_fail++; $display("FAIL decerr_after got %b/%0d want 0/1", decerr_valid, out_cnt); end
    drain_one();
  endtask
  task automatic test_backpressure();
    m_araddr = 32'hC000_0000; m_arlen = 8'd7; m_arvalid = 1'b1;
    step();
    m_araddr = 32'hC000_1234; m_arlen = 8'd9; s_arready = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (s_arvalid !== 4'b1000 || ar_addr !== 32'hC000_0000 || ar_len !== 8'd7) begin n_fail++; $display("FAIL bp_hold%0d got %b/%h/%0d want 1000/c0000000/7", i, s_arvalid, ar_addr, ar_len); end
      n_chk++; if (m_arready !== 1'b0 || sel_push !== 1'b0) begin n_fail++; $display("FAIL bp_block%0d got %b/%b want 0/0", i, m_arready, sel_push); end
      step();
    end
    m_arvalid = 1'b0; s_arready = 4'b1000;
    #1;
    n_chk++; if (sel_push !== 1'b1 || sel_onehot !== 5'b01000) begin n_fail++; $display("FAIL bp_issue got %b/%b want 1/01000", sel_push, sel_onehot); end
    step();
    s_arready = 4'b0;
    n_chk++; if (s_arvalid !== 4'b0 || out_cnt !== 4'd1) begin n_fail++; $display("FAIL bp_after got %b/%0d want 0000/1", s_arvalid, out_cnt); end
    drain_one();
  endtask
  task automatic test_path_switch();
    m_araddr = 32'h0; m_arvalid = 1'b1; s_arready = 4'b0001;
    step();
    m_arvalid = 1'b0;
    n_chk++; if (sel_onehot !== 5'b00001) begin n_fail++; $display("FAIL ps_first got %b want 00001", sel_onehot); end
    step();
    s_arready = 4'b0; m_araddr = 32'h4000_0000; m_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (m_arready !== 1'b0 || out_cnt !== 4'd1) begin n_fail++; $display("FAIL ps_block%0d got %b/%0d want 0/1", i, m_arready, out_cnt); end
      step();
    end
    r_done = 1'b1;
    #1;
    n_chk++; if (m_arready !== 1'b0) begin n_fail++; $display("FAIL ps_rdone_cycle got %b want 0", m_arready); end
    step();
    r_done = 1'b0;
    n_chk++; if (m_arready !== 1'b1 || out_cnt !== 4'd0) begin n_fail++; $display("FAIL ps_open got %b/%0d want 1/0", m_arready, out_cnt); end
    step();
    m_arvalid = 1'b0;
    n_chk++; if (s_arvalid !== 4'b0010 || out_cnt !== 4'd1) begin n_fail++; $display("FAIL ps_accept got %b/%0d want 0010/1", s_arvalid, out_cnt); end
    s_arready = 4'b0010;
    step();
    s_arready = 4'b0;
    drain_one();
  endtask
  task automatic test_limit();
    m_araddr = 32'h0; m_arvalid = 1'b1; s_arready = 4'b0001;
    step();
    n_chk++; if (out_cnt !== 4'd1 || sel_push !== 1'b1 || m_arready !== 1'b1) begin n_fail++; $display("FAIL lim_b2b got %0d/%b/%b want 1/1/1", out_cnt, sel_push, m_arready); end
    step();
    n_chk++; if (out_cnt !== 4'd2 || m_arready !== 1'b0 || sel_push !== 1'b1) begin n_fail++; $display("FAIL lim_full got %0d/%b/%b want 2/0/1", out_cnt, m_arready, sel_push); end
    step();
    n_chk++; if (out_cnt !== 4'd2 || s_arvalid !== 4'b0 || m_arready !== 1'b0) begin n_fail++; $display("FAIL lim_third got %0d/%b/%b want 2/0000/0", out_cnt, s_arvalid, m_arready); end
    r_done = 1'b1;
    step();
    n_chk++; if (out_cnt !== 4'd1 || m_arready !== 1'b1) begin n_fail++; $display("FAIL lim_reopen got %0d/%b want 1/1", out_cnt, m_arready); end
    step();
    r_done = 1'b0; m_arvalid = 1'b0;
    n_chk++; if (out_cnt !== 4'd1 || s_arvalid !== 4'b0001) begin n_fail++; $display("FAIL lim_simul got %0d/%b want 1/0001", out_cnt, s_arvalid); end
    step();
    s_arready = 4'b0;
    drain_one();
    n_chk++; if (out_cnt !== 4'd0) begin n_fail++; $display("FAIL lim_zero got %0d want 0", out_cnt); end
    drain_one();
    n_chk++; if (out_cnt !== 4'd0) begin n_fail++; $display("FAIL lim_underflow got %0d want 0", out_cnt); end
  endtask
  task automatic test_reset_midflight();
    m_araddr = 32'hC000_0000; m_arvalid = 1'b1;
    step();
    m_arvalid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (s_arvalid !== 4'b0 || out_cnt !== 4'd0 || ar_addr !== 32'h0) begin n_fail++; $display("FAIL mid_reset got %b/%0d/%h want 0000/0/0", s_arvalid, out_cnt, ar_addr); end
  endtask
  initial begin
    test_reset();
    test_routing();
    test_decerr();
    test_backpressure();
    test_path_switch();
    test_limit();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
